// File: rtl/kdarwin_pkg.sv
// Shared KDarwin definitions: AXI length width, read-issuer state encoding,
// and a counter width helper.
package kdarwin_pkg;

    // AXI4 arlen field width.
    localparam int unsigned AXI_LEN_W = 8;

    // Read burst issuer control states.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_issuer_state_t;

    // Bits needed to hold the values 0..max_val inclusive (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/kdarwin_rd_burst_issuer_counter.sv
// Up/down counter with synchronous load. Used for the in-flight burst count.
// A decrement at zero is dropped so a stray completion can never wrap it.
module KDarwin_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clken,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_incr,
    input  logic         i_decr,
    output logic [W-1:0] o_count,
    output logic         o_is_zero
);

    logic [W-1:0] r_count;

    // Load wins over counting; simultaneous incr and decr cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_clken) begin
            if (i_incr && !i_decr) begin
                r_count <= r_count + W'(1);
            end else if (!i_incr && i_decr && (r_count != '0)) begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/kdarwin_rd_burst_issuer.sv
// Read-side AXI4 burst issuer: splits one transfer command into AR bursts of
// at most C_BURST_LEN beats, limits in-flight bursts, counts R-last
// completions and pulses ctrl_done when the whole transfer has returned.
module kdarwin_rd_burst_issuer
    import kdarwin_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LENGTH_WIDTH    = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_LENGTH_WIDTH-1:0] ctrl_xfer_size_in_beats,
    output logic                      ctrl_busy,
    output logic                      ctrl_done,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [AXI_LEN_W-1:0]      m_axi_arlen,
    input  logic                      m_axi_rvalid,
    input  logic                      m_axi_rready,
    input  logic                      m_axi_rlast,
    output rd_issuer_state_t          dbg_state
);

    localparam int LP_BPB   = C_DATA_WIDTH / 8;
    localparam int LP_SHIFT = $clog2(C_BURST_LEN);
    localparam int LP_OUT_W = cnt_width(C_MAX_OUTSTANDING);

    localparam logic [C_ADDR_WIDTH-1:0]   LP_STRIDE   = C_ADDR_WIDTH'(C_BURST_LEN * LP_BPB);
    localparam logic [C_LENGTH_WIDTH-1:0] LP_REM_MASK = C_LENGTH_WIDTH'(C_BURST_LEN - 1);
    localparam logic [AXI_LEN_W-1:0]      LP_FULL_LEN = AXI_LEN_W'(C_BURST_LEN - 1);
    localparam logic [LP_OUT_W:0]         LP_MAX_OUT  = (LP_OUT_W + 1)'(C_MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic [C_ADDR_WIDTH-1:0]   r_addr;        // address of the next burst to present
    logic [C_LENGTH_WIDTH-1:0] r_bursts_left; // bursts not yet presented on AR
    logic [C_LENGTH_WIDTH-1:0] r_n_bursts;
    logic [C_LENGTH_WIDTH-1:0] r_comp_cnt;
    logic [AXI_LEN_W-1:0]      r_last_len;
    logic                      r_arvalid;
    logic [C_ADDR_WIDTH-1:0]   r_araddr;
    logic [AXI_LEN_W-1:0]      r_arlen;
    logic                      r_busy;
    logic                      r_done;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. Once arvalid is raised, araddr/arlen/arvalid hold until
    // arready is seen; R is only observed and a burst completes on
    // rvalid & rready & rlast.
    logic                      w_ar_hs;
    logic                      w_rl_hs;
    logic                      w_accept;
    logic [C_LENGTH_WIDTH-1:0] w_rem;
    logic [C_LENGTH_WIDTH-1:0] w_n_bursts;
    logic [AXI_LEN_W-1:0]      w_last_len;
    logic                      w_comp_act;
    logic [C_LENGTH_WIDTH-1:0] w_comp_next;
    logic [LP_OUT_W-1:0]       w_out_cnt;
    logic                      w_out_zero;
    logic [LP_OUT_W:0]         w_inflight;
    logic                      w_present;

    assign w_ar_hs  = r_arvalid & m_axi_arready;
    assign w_rl_hs  = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign w_accept = (r_state == S_IDLE) & ctrl_start;

    // Burst count and final length from the low/high bits of the size.
    assign w_rem      = ctrl_xfer_size_in_beats & LP_REM_MASK;
    assign w_n_bursts = (ctrl_xfer_size_in_beats >> LP_SHIFT)
                      + {{(C_LENGTH_WIDTH-1){1'b0}}, (w_rem != '0)};
    assign w_last_len = (w_rem == '0) ? LP_FULL_LEN : AXI_LEN_W'(w_rem - C_LENGTH_WIDTH'(1));

    assign w_comp_act  = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) & w_rl_hs;
    assign w_comp_next = r_comp_cnt + {{(C_LENGTH_WIDTH-1){1'b0}}, w_comp_act};

    // Credit check counts the burst handshaking this cycle but not a
    // same-cycle completion, so a new burst never overshoots the limit.
    assign w_inflight = {1'b0, w_out_cnt} + {{LP_OUT_W{1'b0}}, w_ar_hs};
    assign w_present  = (r_state == S_ISSUE) && (r_bursts_left != '0)
                     && (w_inflight < LP_MAX_OUT) && (!r_arvalid || w_ar_hs);

    KDarwin_counter #(
        .W (LP_OUT_W)
    ) u_outstanding (
        .clk          (clk),
        .rst          (rst),
        .i_clken      (1'b1),
        .i_load       (w_accept),
        .i_load_value ('0),
        .i_incr       (w_ar_hs),
        .i_decr       (w_rl_hs),
        .o_count      (w_out_cnt),
        .o_is_zero    (w_out_zero)
    );

    // Control FSM, AR channel registers and completion counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_bursts_left <= '0;
            r_n_bursts    <= '0;
            r_comp_cnt    <= '0;
            r_last_len    <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_comp_act) begin
                r_comp_cnt <= w_comp_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        r_busy        <= 1'b1;
                        r_addr        <= ctrl_addr_offset;
                        r_bursts_left <= w_n_bursts;
                        r_n_bursts    <= w_n_bursts;
                        r_last_len    <= w_last_len;
                        r_comp_cnt    <= '0;
                        r_state       <= (ctrl_xfer_size_in_beats == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_present) begin
                        r_arvalid     <= 1'b1;
                        r_araddr      <= r_addr;
                        r_arlen       <= (r_bursts_left == C_LENGTH_WIDTH'(1)) ? r_last_len : LP_FULL_LEN;
                        r_addr        <= r_addr + LP_STRIDE;
                        r_bursts_left <= r_bursts_left - C_LENGTH_WIDTH'(1);
                    end else if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                    end
                    if (w_ar_hs && (r_bursts_left == '0)) begin
                        if (w_comp_next == r_n_bursts) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_zero && (r_comp_cnt == r_n_bursts)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // DONE stays until its one-cycle pulse has been emitted;
                    // the zero-length path arrives here with the pulse pending.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign ctrl_busy     = r_busy;
    assign ctrl_done     = r_done;
    assign dbg_state     = rd_issuer_state_t'(r_state);

endmodule

// File: tb/tb_kdarwin_rd_burst_issuer.sv
// Self-checking bench for kdarwin_rd_burst_issuer: directed scenarios plus
// randomized transfers against a burst-list reference model.
module tb_kdarwin_rd_burst_issuer;
  import kdarwin_pkg::*;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int LW = 32;
  localparam int BL = 16;
  localparam int MO = 4;
  localparam logic [63:0] STRIDE = 64'h400;

  logic             clk;
  logic             rst;
  logic             ctrl_start;
  logic [AW-1:0]    ctrl_addr_offset;
  logic [LW-1:0]    ctrl_xfer_size_in_beats;
  logic             ctrl_busy;
  logic             ctrl_done;
  logic             m_axi_arvalid;
  logic             m_axi_arready;
  logic [AW-1:0]    m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic             m_axi_rvalid;
  logic             m_axi_rready;
  logic             m_axi_rlast;
  rd_issuer_state_t dbg_state;

  kdarwin_rd_burst_issuer #(
    .C_ADDR_WIDTH      (AW),
    .C_DATA_WIDTH      (DW),
    .C_LENGTH_WIDTH    (LW),
    .C_BURST_LEN       (BL),
    .C_MAX_OUTSTANDING (MO)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_beats (ctrl_xfer_size_in_beats),
    .ctrl_busy               (ctrl_busy),
    .ctrl_done               (ctrl_done),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .m_axi_rvalid            (m_axi_rvalid),
    .m_axi_rready            (m_axi_rready),
    .m_axi_rlast             (m_axi_rlast),
    .dbg_state               (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [71:0] exp_q[$];
  int n_checks, n_pass;
  int inflight, ar_cnt, rl_cnt, n_exp, cyc, done_due, ar_deadline;
  bit done_seen, ar_seen, prev_arvalid, prev_ar_hs;
  logic [63:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    ctrl_start    = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_rlast   = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    inflight     = 0;
    prev_arvalid = 0;
    prev_ar_hs   = 0;
    done_due     = -100;
    ar_deadline  = -100;
  endtask

  // One cycle of reset, then outputs must all read their reset values.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    check("rst_arvalid", 72'(m_axi_arvalid), 72'(0));
    check("rst_araddr",  72'(m_axi_araddr),  72'(0));
    check("rst_arlen",   72'(m_axi_arlen),   72'(0));
    check("rst_busy",    72'(ctrl_busy),     72'(0));
    check("rst_done",    72'(ctrl_done),     72'(0));
    check("rst_state",   72'(dbg_state),     72'(RD_IDLE));
    rst = 1'b0;
    clear_model();
  endtask

  // Reference: list of (address, arlen) bursts from the command.
  task automatic start_xfer(input logic [63:0] addr, input int size);
    int nb;
    int left;
    int this_len;
    clear_model();
    nb   = 0;
    left = size;
    while (left > 0) begin
      this_len = (left > BL) ? BL : left;
      exp_q.push_back({addr + 64'(nb) * STRIDE, 8'(this_len - 1)});
      left -= this_len;
      nb++;
    end
    n_exp       = nb;
    ar_cnt      = 0;
    rl_cnt      = 0;
    done_seen   = 0;
    ar_seen     = 0;
    done_due    = (size == 0) ? cyc + 2 : -100;
    ar_deadline = (size == 0) ? -100 : cyc + 2;
    idle_inputs();
    ctrl_start              = 1'b1;
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_beats = 32'(size);
    tick();
    ctrl_start = 1'b0;
    check("busy_rise", 72'(ctrl_busy), 72'(1));
  endtask

  // One clock of driving, protocol checks and model update.
  task automatic step(input int ar_pct, input int r_pct);
    bit rl_fire;
    logic [71:0] e;
    if (m_axi_arvalid) begin
      if (prev_arvalid && !prev_ar_hs)
        check("ar_stable", {m_axi_araddr, m_axi_arlen}, {prev_addr, prev_len});
      else
        check("ar_credit", 72'(inflight < MO), 72'(1));
      ar_seen = 1;
    end
    if (cyc == ar_deadline) check("ar_first", 72'(ar_seen), 72'(1));
    if (ctrl_done || cyc == done_due) check("done_time", 72'(ctrl_done), 72'(cyc == done_due));
    if (ctrl_done) done_seen = 1;

    // Stray start pulses while busy must be ignored.
    ctrl_start              = ($urandom_range(0, 7) == 0);
    ctrl_addr_offset        = {$urandom, $urandom};
    ctrl_xfer_size_in_beats = $urandom;
    m_axi_arready = ($urandom_range(0, 99) < ar_pct);
    rl_fire = (inflight > 0) && ($urandom_range(0, 99) < r_pct);
    if (rl_fire) begin
      m_axi_rvalid = 1'b1;
      m_axi_rready = 1'b1;
      m_axi_rlast  = 1'b1;
    end else begin
      m_axi_rvalid = 1'($urandom_range(0, 1));
      m_axi_rready = 1'($urandom_range(0, 1));
      m_axi_rlast  = !(m_axi_rvalid && m_axi_rready) && 1'($urandom_range(0, 1));
    end

    prev_arvalid = m_axi_arvalid;
    prev_ar_hs   = m_axi_arvalid && m_axi_arready;
    prev_addr    = m_axi_araddr;
    prev_len     = m_axi_arlen;
    if (prev_ar_hs) begin
      check("ar_expected", 72'(exp_q.size() > 0), 72'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ar_burst", {m_axi_araddr, m_axi_arlen}, e);
      end
      ar_cnt++;
      inflight++;
    end
    if (rl_fire) begin
      inflight--;
      rl_cnt++;
      if (rl_cnt == n_exp) done_due = cyc + 2;
    end
    tick();
  endtask

  task automatic run_until_done(input int ar_pct, input int r_pct);
    int budget;
    budget = 4000;
    while (!done_seen && budget > 0) begin
      step(ar_pct, r_pct);
      budget--;
    end
    idle_inputs();
    check("done_seen", 72'(done_seen), 72'(1));
    check("ar_count",  72'(ar_cnt),    72'(n_exp));
    check("busy_fall", 72'({ctrl_busy, ctrl_done}), 72'(0));
    if (!done_seen) do_reset();
  endtask

  initial begin
    logic [63:0] addr;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst      = 1'b1;
    ctrl_addr_offset        = '0;
    ctrl_xfer_size_in_beats = '0;
    idle_inputs();
    clear_model();
    tick();
    do_reset();

    // Three bursts, last one 8 beats.
    start_xfer(64'h1000, 40);
    run_until_done(100, 30);

    // Zero length: done at T+2, no AR.
    start_xfer(64'h40, 0);
    run_until_done(100, 100);

    // Credit limit: four bursts then hold until a completion returns.
    start_xfer(64'h2000, 160);
    repeat (20) step(100, 0);
    check("credit_ars",  72'(ar_cnt),        72'(4));
    check("credit_hold", 72'(m_axi_arvalid), 72'(0));
    step(100, 100);
    repeat (4) step(100, 0);
    check("credit_next", 72'(ar_cnt), 72'(5));
    run_until_done(100, 40);

    // AR backpressure for five cycles.
    start_xfer(64'h3000, 20);
    for (int i = 0; i < 4 && !m_axi_arvalid; i++) step(0, 0);
    check("bp_valid", 72'(m_axi_arvalid), 72'(1));
    repeat (5) step(0, 0);
    check("bp_no_hs", 72'(ar_cnt), 72'(0));
    step(100, 0);
    check("bp_hs", 72'(ar_cnt), 72'(1));
    run_until_done(60, 40);

    // Stray rlast in idle must not disturb the in-flight count.
    m_axi_rvalid = 1'b1;
    m_axi_rready = 1'b1;
    m_axi_rlast  = 1'b1;
    tick();
    idle_inputs();
    start_xfer(64'h8000, 80);
    repeat (12) step(100, 0);
    check("stray_ars", 72'(ar_cnt), 72'(4));
    run_until_done(100, 50);

    // Address wraps past the top of the address space.
    start_xfer(64'hFFFF_FFFF_FFFF_F800, 48);
    run_until_done(80, 50);

    // Reset in the middle of a ten-burst transfer, then a fresh command.
    start_xfer(64'h5000, 160);
    for (int i = 0; i < 200 && ar_cnt < 2; i++) step(100, 0);
    check("pre_rst_ars", 72'(ar_cnt), 72'(2));
    do_reset();
    start_xfer(64'h0, 16);
    run_until_done(100, 50);

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      addr = {$urandom, $urandom} & ~64'h3F;
      start_xfer(addr, int'($urandom_range(0, 90)));
      run_until_done(int'($urandom_range(30, 100)), int'($urandom_range(15, 80)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
